// File: rtl/final385_soc_debug_ocimem_arb.sv
// rtl/final385_soc_debug_ocimem_arb.sv - JTAG debug / Avalon arbiter for the OCI memory.
// Define FINAL385_SOC_DEBUG_ARB_RR_EN for round-robin arbitration (default: JTAG fixed priority).
module final385_soc_debug_ocimem_arb (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  input  logic [37:0] jdo,
  input  logic [7:0]  av_address,
  input  logic        av_read,
  input  logic        av_write,
  input  logic [31:0] av_writedata,
  input  logic [3:0]  av_byteenable,
  output logic [31:0] av_readdata,
  output logic        av_waitrequest,
  output logic [7:0]  ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_byteen,
  output logic        ram_wren,
  input  logic [31:0] ram_q,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        jtag_overrun
);

  typedef enum logic [2:0] {IDLE, J_RD, J_CAP, J_WR, A_RD, A_CAP, A_WR} state_t;

  state_t      state, state_nxt;
  logic [7:0]  mon_a_reg;
  logic        pend_valid;
  logic        pend_write;
  logic [31:0] pend_data;

  logic any_strobe, multi_strobe, j_busy, accept, new_op, new_write;
  logic j_req, j_write, av_req, grant_j, take_j;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[16:11], jdo[2:0]};

  // Strobe priority is b > a > no_action; losers in the same cycle count as overrun.
  assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign multi_strobe = (take_action_ocimem_a & take_action_ocimem_b) |
                        (take_action_ocimem_a & take_no_action_ocimem_a) |
                        (take_action_ocimem_b & take_no_action_ocimem_a);
  assign j_busy       = pend_valid | (state == J_RD) | (state == J_CAP) | (state == J_WR);
  assign accept       = any_strobe & ~j_busy;
  assign new_write    = take_action_ocimem_b;
  assign new_op       = accept & (take_action_ocimem_b |
                                  (take_action_ocimem_a & jdo[17]) |
                                  (~take_action_ocimem_a & take_no_action_ocimem_a));

  // A strobe is visible to the arbiter in its own cycle, so it competes fairly with Avalon.
  assign j_req   = pend_valid | new_op;
  assign j_write = pend_valid ? pend_write : new_write;
  assign av_req  = av_read | av_write;

`ifdef FINAL385_SOC_DEBUG_ARB_RR_EN
  logic last_grant_j;

  assign grant_j = j_req & (~av_req | ~last_grant_j);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_j <= 1'b0;
    end else if (state == IDLE) begin
      if (grant_j) last_grant_j <= 1'b1;
      else if (av_req) last_grant_j <= 1'b0;
    end
  end
`else
  assign grant_j = j_req;
`endif

  assign take_j = (state == IDLE) & grant_j;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    ram_addr       = mon_a_reg;
    ram_wdata      = pend_data;
    ram_byteen     = 4'hF;
    ram_wren       = 1'b0;
    av_waitrequest = 1'b1;
    av_readdata    = 32'h0;
    case (state)
      IDLE: begin
        if (grant_j) state_nxt = j_write ? J_WR : J_RD;
        else if (av_read) state_nxt = A_RD;
        else if (av_write) state_nxt = A_WR;
      end
      J_RD:  state_nxt = J_CAP;
      J_CAP: state_nxt = IDLE;
      J_WR: begin
        ram_wren  = 1'b1;
        state_nxt = IDLE;
      end
      A_RD: begin
        ram_addr  = av_address;
        state_nxt = A_CAP;
      end
      A_CAP: begin
        av_readdata    = ram_q;
        av_waitrequest = 1'b0;
        state_nxt      = IDLE;
      end
      A_WR: begin
        ram_addr       = av_address;
        ram_wdata      = av_writedata;
        ram_byteen     = av_byteenable;
        ram_wren       = 1'b1;
        av_waitrequest = 1'b0;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_write <= 1'b0;
      pend_data  <= 32'h0;
    end else begin
      if (new_op) begin
        pend_write <= new_write;
        pend_data  <= jdo[34:3];
      end
      if (take_j) pend_valid <= 1'b0;
      else if (new_op) pend_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_a_reg     <= 8'h0;
      MonDReg       <= 32'h0;
      monitor_ready <= 1'b0;
      jtag_overrun  <= 1'b0;
    end else begin
      if (accept & take_action_ocimem_a & ~take_action_ocimem_b)
        mon_a_reg <= jdo[10:3];
      else if ((state == J_CAP) || (state == J_WR))
        mon_a_reg <= mon_a_reg + 8'd1;
      if (state == J_CAP) MonDReg <= ram_q;
      if (accept) monitor_ready <= 1'b0;
      else if (state == J_CAP) monitor_ready <= 1'b1;
      if (any_strobe & (j_busy | multi_strobe)) jtag_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_final385_soc_debug_ocimem_arb.sv
// tb/tb_final385_soc_debug_ocimem_arb.sv - scoreboard bench for the OCI memory arbiter.
module tb_final385_soc_debug_ocimem_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [37:0] jdo;
  logic [7:0]  av_address;
  logic        av_read, av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_byteen;
  logic        ram_wren;
  logic [31:0] ram_q;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        jtag_overrun;

  always #5 clk = ~clk;

  final385_soc_debug_ocimem_arb dut (
    .clk(clk), .reset_n(reset_n),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .jdo(jdo),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_byteenable(av_byteenable),
    .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_byteen(ram_byteen),
    .ram_wren(ram_wren), .ram_q(ram_q),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .jtag_overrun(jtag_overrun)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // RAM model with registered read; contents preloaded on the first clock edge.
  logic [31:0] mem [256];
  logic        ram_init = 1'b0;

  function automatic logic [31:0] preload_val(input int i);
    case (i)
      8'h00:   return 32'h0000A5A5;
      8'h02:   return 32'h22222222;
      8'h03:   return 32'h33333333;
      8'h11:   return 32'h11111111;
      8'h20:   return 32'hCAFEF00D;
      8'h30:   return 32'hFFFFFFFF;
      8'hFF:   return 32'h12345678;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= preload_val(i);
      ram_init <= 1'b1;
    end else if (ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
    ram_q <= mem[ram_addr];
  end

  logic [43:0] exp_wr [$];
  logic [31:0] exp_rd [$];
  logic [31:0] exp_mon [$];
  logic        prev_ready = 1'b0;
  int          mon_rises = 0;

  always @(negedge clk) begin
    if (ram_wren) begin
      if (exp_wr.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ram_write: got addr=%0h data=%0h want none", ram_addr, ram_wdata);
      end else chk("ram_write", {20'h0, ram_addr, ram_wdata, ram_byteen}, {20'h0, exp_wr.pop_front()});
    end
    if (reset_n && av_read && !av_waitrequest) begin
      if (exp_rd.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_av_read: got %0h want none", av_readdata);
      end else chk("av_readdata", {32'h0, av_readdata}, {32'h0, exp_rd.pop_front()});
    end
    if (monitor_ready && !prev_ready) begin
      mon_rises <= mon_rises + 1;
      if (exp_mon.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_monitor_ready: got %0h want none", MonDReg);
      end else chk("MonDReg", {32'h0, MonDReg}, {32'h0, exp_mon.pop_front()});
    end
    prev_ready <= monitor_ready;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [37:0] jaddr(input logic [7:0] a, input logic rd);
    logic [37:0] r;
    r = '0; r[10:3] = a; r[17] = rd;
    return r;
  endfunction

  function automatic logic [37:0] jdata(input logic [31:0] d);
    logic [37:0] r;
    r = '0; r[34:3] = d;
    return r;
  endfunction

  // kind: 0 = take_action_a, 1 = take_action_b, 2 = take_no_action_a
  task automatic jstrobe(input int kind, input logic [37:0] d);
    jdo = d;
    take_action_ocimem_a    = (kind == 0);
    take_action_ocimem_b    = (kind == 1);
    take_no_action_ocimem_a = (kind == 2);
    cyc();
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic av_xfer(input logic rd, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic with_b, input logic [31:0] bdata,
                         output int n);
    logic done;
    av_address = a; av_writedata = d; av_byteenable = be;
    if (rd) av_read = 1'b1; else av_write = 1'b1;
    if (with_b) begin jdo = jdata(bdata); take_action_ocimem_b = 1'b1; end
    n = 0; done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      done = !av_waitrequest;
      n++;
      @(posedge clk); #1;
      take_action_ocimem_b = 1'b0;
    end
    av_read = 1'b0; av_write = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL av_timeout: got no completion in %0d cycles want completion", n);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_waitrequest"}, 64'(av_waitrequest), 64'd1);
    chk({tag, "_ram_wren"}, 64'(ram_wren), 64'd0);
    chk({tag, "_readdata"}, 64'(av_readdata), 64'd0);
    chk({tag, "_MonDReg"}, 64'(MonDReg), 64'd0);
    chk({tag, "_monitor_ready"}, 64'(monitor_ready), 64'd0);
    chk({tag, "_overrun"}, 64'(jtag_overrun), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, rises0;
    reset_n = 1'b0;
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
    jdo = '0; av_address = '0; av_read = 1'b0; av_write = 1'b0;
    av_writedata = '0; av_byteenable = '0;
    cyc(3);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    cyc(2);

    // JTAG write at 0x10, then a read confirms the address advanced to 0x11.
    jstrobe(0, jaddr(8'h10, 1'b0));
    cyc(2);
    exp_wr.push_back({8'h10, 32'hDEADBEEF, 4'hF});
    jstrobe(1, jdata(32'hDEADBEEF));
    cyc(3);
    chk("mem_10", {32'h0, mem[8'h10]}, 64'hDEADBEEF);
    exp_mon.push_back(32'h11111111);
    jstrobe(2, '0);
    cyc(5);

    // JTAG read at 0xFF with latency check, then wrap to 0x00.
    exp_mon.push_back(32'h12345678);
    jdo = jaddr(8'hFF, 1'b1);
    take_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    k = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) chk("ready_cleared", 64'(monitor_ready), 64'd0);
      if (monitor_ready && k == 0) k = i;
    end
    chk("ready_latency", 64'(k), 64'd3);
    cyc();
    exp_mon.push_back(32'h0000A5A5);
    jstrobe(2, '0);
    cyc(5);

    // Conflict: JTAG write (addr 0x01) and Avalon write (0x30) in the same cycle.
`ifdef FINAL385_SOC_DEBUG_ARB_RR_EN
    exp_wr.push_back({8'h30, 32'h11223344, 4'b0101});
    exp_wr.push_back({8'h01, 32'h0BADF00D, 4'hF});
    av_xfer(1'b0, 8'h30, 32'h11223344, 4'b0101, 1'b1, 32'h0BADF00D, n);
    chk("conflict_av_cycles", 64'(n), 64'd2);
`else
    exp_wr.push_back({8'h01, 32'h0BADF00D, 4'hF});
    exp_wr.push_back({8'h30, 32'h11223344, 4'b0101});
    av_xfer(1'b0, 8'h30, 32'h11223344, 4'b0101, 1'b1, 32'h0BADF00D, n);
    chk("conflict_av_cycles", 64'(n), 64'd4);
`endif
    cyc(3);
    chk("mem_30", {32'h0, mem[8'h30]}, 64'hFF22FF44);
    chk("mem_01", {32'h0, mem[8'h01]}, 64'h0BADF00D);

    // Avalon read with no JTAG activity.
    exp_rd.push_back(32'hCAFEF00D);
    av_xfer(1'b1, 8'h20, 32'h0, 4'h0, 1'b0, 32'h0, n);
    chk("av_read_cycles", 64'(n), 64'd3);
    cyc(2);

    // Back-to-back no_action strobes: second is dropped.
    rises0 = mon_rises;
    exp_mon.push_back(32'h22222222);
    jstrobe(2, '0);
    jstrobe(2, '0);
    cyc(6);
    chk("overrun_set", 64'(jtag_overrun), 64'd1);
    chk("overrun_one_read", 64'(mon_rises - rises0), 64'd1);

    // Reset while J_WR is being set up.
    jdo = jdata(32'h55555555);
    take_action_ocimem_b = 1'b1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    take_action_ocimem_b = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc(3);
    chk("mem_03_untouched", {32'h0, mem[8'h03]}, 64'h33333333);
    exp_wr.push_back({8'h40, 32'h77778888, 4'hF});
    av_xfer(1'b0, 8'h40, 32'h77778888, 4'hF, 1'b0, 32'h0, n);
    chk("post_reset_write_cycles", 64'(n), 64'd2);
    cyc(2);
    chk("mem_40", {32'h0, mem[8'h40]}, 64'h77778888);

    chk("wr_queue_left", 64'(exp_wr.size()), 64'd0);
    chk("rd_queue_left", 64'(exp_rd.size()), 64'd0);
    chk("mon_queue_left", 64'(exp_mon.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
